// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM states, selector encodings, default width.
package atm_pkg;

  localparam int unsigned ATM_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PIN_WAIT = 2'b01,
    MENU     = 2'b10,
    LOCKED   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SEL_INQ  = 2'b00,
    SEL_WD   = 2'b01,
    SEL_DEP  = 2'b10,
    SEL_EXIT = 2'b11
  } sel_t;

endpackage

// File: rtl/atm_balance_alu.sv
// Combinational balance update: withdraw/deposit with underflow and overflow rejection.
// Also used by the display datapath, so it carries no state.
module atm_balance_alu
  import atm_pkg::*;
#(
  parameter int unsigned W = ATM_W
) (
  input  logic [W-1:0] bal,
  input  logic [W-1:0] amt,
  input  logic [1:0]   sel,
  output logic [W-1:0] next_bal,
  output logic         wd_err,
  output logic         ovf_err
);

  logic [W:0] sum;

  always_comb begin
    sum      = {1'b0, bal} + {1'b0, amt};
    next_bal = bal;
    wd_err   = 1'b0;
    ovf_err  = 1'b0;
    case (sel_t'(sel))
      SEL_WD: begin
        if (amt > bal) wd_err = 1'b1;
        else           next_bal = bal - amt;
      end
      SEL_DEP: begin
        // Carry out of the W+1 bit sum means the deposit cannot fit.
        if (sum[W]) ovf_err = 1'b1;
        else        next_bal = sum[W-1:0];
      end
      default: next_bal = bal;
    endcase
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session FSM: PIN check with lockout, then inquiry/withdraw/deposit/exit on the balance.
// Optional idle auto-logout is enabled by defining ATM_TIMEOUT_EN.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned W         = ATM_W,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned INIT_BAL  = 0,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         card_in,
  input  logic [W-1:0] prefed,
  input  logic [W-1:0] pin,
  input  logic         pin_valid,
  input  logic [1:0]   sel,
  input  logic [W-1:0] amt,
  input  logic         txn_valid,
  output logic [W-1:0] dout,
  output logic         signal,
  output logic         wd,
  output logic         ovf,
  output logic         done,
  output logic         auth,
  output logic [2:0]   tries
);

  state_t       state;
  logic [W-1:0] next_bal;
  logic         wd_err;
  logic         ovf_err;
  logic [2:0]   tries_inc;
  logic         timeout_hit_c;

  assign tries_inc = tries + 3'd1;

  // dout doubles as the balance register.
  atm_balance_alu #(.W(W)) u_alu (
    .bal      (dout),
    .amt      (amt),
    .sel      (sel),
    .next_bal (next_bal),
    .wd_err   (wd_err),
    .ovf_err  (ovf_err)
  );

`ifdef ATM_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          in_session_c;
  logic          accepted_c;

  assign in_session_c  = (state == PIN_WAIT) || (state == MENU);
  assign accepted_c    = ((state == PIN_WAIT) && pin_valid) || ((state == MENU) && txn_valid);
  assign timeout_hit_c = in_session_c && card_in && !accepted_c &&
                         (idle_cnt == TW'(TIMEOUT - 1));

  // Counts consecutive idle cycles inside a session; any activity or state change restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!in_session_c || !card_in || accepted_c || timeout_hit_c) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dout   <= W'(INIT_BAL);
      signal <= 1'b0;
      wd     <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      auth   <= 1'b0;
      tries  <= 3'd0;
    end else begin
      wd   <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (card_in) state <= PIN_WAIT;
        end
        PIN_WAIT: begin
          if (!card_in || timeout_hit_c) begin
            state <= IDLE;
          end else if (pin_valid) begin
            if (pin == prefed) begin
              state <= MENU;
              auth  <= 1'b1;
              tries <= 3'd0;
            end else begin
              tries <= tries_inc;
              if (tries_inc == 3'(MAX_TRIES)) begin
                state  <= LOCKED;
                signal <= 1'b1;
              end
            end
          end
        end
        MENU: begin
          if (!card_in || timeout_hit_c) begin
            state <= IDLE;
            auth  <= 1'b0;
          end else if (txn_valid) begin
            dout <= next_bal;
            wd   <= wd_err;
            ovf  <= ovf_err;
            done <= !(wd_err || ovf_err);
            if (sel_t'(sel) == SEL_EXIT) begin
              state <= IDLE;
              auth  <= 1'b0;
              tries <= 3'd0;
            end
          end
        end
        LOCKED: begin
          // Only reset leaves lockout.
          signal <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: driver queues expected outputs, monitor compares each cycle.
module tb_atm_session_ctrl;

  localparam logic [3:0] PREFED = 4'b0110;

  typedef struct {
    string      name;
    logic [3:0] dout;
    logic       signal;
    logic       wd;
    logic       ovf;
    logic       done;
    logic       auth;
    logic [2:0] tries;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       card_in;
  logic [3:0] prefed;
  logic [3:0] pin;
  logic       pin_valid;
  logic [1:0] sel;
  logic [3:0] amt;
  logic       txn_valid;
  logic [3:0] dout;
  logic       signal;
  logic       wd;
  logic       ovf;
  logic       done;
  logic       auth;
  logic [2:0] tries;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  atm_session_ctrl #(
    .W(4), .MAX_TRIES(3), .INIT_BAL(0), .TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .card_in   (card_in),
    .prefed    (prefed),
    .pin       (pin),
    .pin_valid (pin_valid),
    .sel       (sel),
    .amt       (amt),
    .txn_valid (txn_valid),
    .dout      (dout),
    .signal    (signal),
    .wd        (wd),
    .ovf       (ovf),
    .done      (done),
    .auth      (auth),
    .tries     (tries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s.%s: got %b, expected %b", name, field, act, req);
  endtask

  // Monitor: outputs settle after each posedge; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "dout",   dout,         e.dout);
        chk(e.name, "signal", {3'b0, signal}, {3'b0, e.signal});
        chk(e.name, "wd",     {3'b0, wd},     {3'b0, e.wd});
        chk(e.name, "ovf",    {3'b0, ovf},    {3'b0, e.ovf});
        chk(e.name, "done",   {3'b0, done},   {3'b0, e.done});
        chk(e.name, "auth",   {3'b0, auth},   {3'b0, e.auth});
        chk(e.name, "tries",  {1'b0, tries},  {1'b0, e.tries});
      end else if (wd === 1'b1 || ovf === 1'b1 || done === 1'b1) begin
        checks++;
        $display("FAIL unexpected_pulse: got wd=%b ovf=%b done=%b, expected none", wd, ovf, done);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string name, input logic r, input logic ci,
                      input logic [3:0] p, input logic pv,
                      input logic [1:0] s, input logic [3:0] a, input logic tv,
                      input logic [3:0] e_dout, input logic e_sig, input logic e_wd,
                      input logic e_ovf, input logic e_done, input logic e_auth,
                      input logic [2:0] e_tries);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; card_in = ci; pin = p; pin_valid = pv; sel = s; amt = a; txn_valid = tv;
    e.name = name; e.dout = e_dout; e.signal = e_sig; e.wd = e_wd; e.ovf = e_ovf;
    e.done = e_done; e.auth = e_auth; e.tries = e_tries;
    exp_q.push_back(e);
  endtask

  initial begin
    int budget;
    rst = 1'b1; card_in = 1'b0; prefed = PREFED; pin = 4'd0; pin_valid = 1'b0;
    sel = 2'b00; amt = 4'd0; txn_valid = 1'b0;

    //    name              rst ci pin     pv sel    amt     tv  dout    sig wd ovf dn au tries
    step("reset",           1, 0, 4'h0,   0, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd0);
    step("card_in",         0, 1, 4'h0,   0, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd0);
    step("pin_ok",          0, 1, 4'h6,   1, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 1, 3'd0);
    step("dep5",            0, 1, 4'h0,   0, 2'b10, 4'h5,   1,  4'd5,   0, 0, 0, 1, 1, 3'd0);
    step("wd3",             0, 1, 4'h0,   0, 2'b01, 4'h3,   1,  4'd2,   0, 0, 0, 1, 1, 3'd0);
    step("wd_reject",       0, 1, 4'h0,   0, 2'b01, 4'h3,   1,  4'd2,   0, 1, 0, 0, 1, 3'd0);
    step("idle_menu",       0, 1, 4'h0,   0, 2'b01, 4'h3,   0,  4'd2,   0, 0, 0, 0, 1, 3'd0);
    step("pin_in_menu",     0, 1, 4'h3,   1, 2'b00, 4'h0,   0,  4'd2,   0, 0, 0, 0, 1, 3'd0);
    step("inquiry",         0, 1, 4'h0,   0, 2'b00, 4'h9,   1,  4'd2,   0, 0, 0, 1, 1, 3'd0);
    step("dep10",           0, 1, 4'h0,   0, 2'b10, 4'hA,   1,  4'd12,  0, 0, 0, 1, 1, 3'd0);
    step("dep_ovf",         0, 1, 4'h0,   0, 2'b10, 4'h5,   1,  4'd12,  0, 0, 1, 0, 1, 3'd0);
    step("dep_to_max",      0, 1, 4'h0,   0, 2'b10, 4'h3,   1,  4'd15,  0, 0, 0, 1, 1, 3'd0);
    step("wd_zero",         0, 1, 4'h0,   0, 2'b01, 4'h0,   1,  4'd15,  0, 0, 0, 1, 1, 3'd0);
    step("dep_zero",        0, 1, 4'h0,   0, 2'b10, 4'h0,   1,  4'd15,  0, 0, 0, 1, 1, 3'd0);
    step("wd_all",          0, 1, 4'h0,   0, 2'b01, 4'hF,   1,  4'd0,   0, 0, 0, 1, 1, 3'd0);
    step("dep15",           0, 1, 4'h0,   0, 2'b10, 4'hF,   1,  4'd15,  0, 0, 0, 1, 1, 3'd0);
    step("exit",            0, 1, 4'h0,   0, 2'b11, 4'h0,   1,  4'd15,  0, 0, 0, 1, 0, 3'd0);
    step("reinsert",        0, 1, 4'h0,   0, 2'b00, 4'h0,   0,  4'd15,  0, 0, 0, 0, 0, 3'd0);
    step("bad1",            0, 1, 4'h3,   1, 2'b00, 4'h0,   0,  4'd15,  0, 0, 0, 0, 0, 3'd1);
    step("txn_in_pin",      0, 1, 4'h0,   0, 2'b10, 4'h1,   1,  4'd15,  0, 0, 0, 0, 0, 3'd1);
    step("bad2",            0, 1, 4'h3,   1, 2'b00, 4'h0,   0,  4'd15,  0, 0, 0, 0, 0, 3'd2);
    step("card_out_pin",    0, 0, 4'h0,   0, 2'b00, 4'h0,   0,  4'd15,  0, 0, 0, 0, 0, 3'd2);
    step("pin_in_idle",     0, 0, 4'h6,   1, 2'b00, 4'h0,   0,  4'd15,  0, 0, 0, 0, 0, 3'd2);
    step("reinsert2",       0, 1, 4'h0,   0, 2'b00, 4'h0,   0,  4'd15,  0, 0, 0, 0, 0, 3'd2);
    step("bad3_lock",       0, 1, 4'h3,   1, 2'b00, 4'h0,   0,  4'd15,  1, 0, 0, 0, 0, 3'd3);
    step("pin_after_lock",  0, 1, 4'h6,   1, 2'b00, 4'h0,   0,  4'd15,  1, 0, 0, 0, 0, 3'd3);
    step("locked_hold",     0, 0, 4'h0,   0, 2'b10, 4'h1,   1,  4'd15,  1, 0, 0, 0, 0, 3'd3);
    step("reset_clears",    1, 0, 4'h0,   0, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd0);
    step("card_in2",        0, 1, 4'h0,   0, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd0);
    step("seq_bad1",        0, 1, 4'h3,   1, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd1);
    step("seq_bad2",        0, 1, 4'h3,   1, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd2);
    step("seq_bad3",        0, 1, 4'h3,   1, 2'b00, 4'h0,   0,  4'd0,   1, 0, 0, 0, 0, 3'd3);
    step("seq_ignored",     0, 1, 4'h6,   1, 2'b00, 4'h0,   0,  4'd0,   1, 0, 0, 0, 0, 3'd3);
    step("reset2",          1, 1, 4'h0,   0, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd0);
    step("card_in3",        0, 1, 4'h0,   0, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd0);
    step("bad_then_ok",     0, 1, 4'h3,   1, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd1);
    step("ok_clears_tries", 0, 1, 4'h6,   1, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 1, 3'd0);
    step("both_strobes",    0, 1, 4'h3,   1, 2'b10, 4'h4,   1,  4'd4,   0, 0, 0, 1, 1, 3'd0);
    step("card_out_menu",   0, 0, 4'h0,   0, 2'b10, 4'h4,   1,  4'd4,   0, 0, 0, 0, 0, 3'd0);
    step("card_in4",        0, 1, 4'h0,   0, 2'b00, 4'h0,   0,  4'd4,   0, 0, 0, 0, 0, 3'd0);
    step("pin_ok2",         0, 1, 4'h6,   1, 2'b00, 4'h0,   0,  4'd4,   0, 0, 0, 0, 1, 3'd0);
    step("rst_wins",        1, 1, 4'h0,   0, 2'b10, 4'h3,   1,  4'd0,   0, 0, 0, 0, 0, 3'd0);
    step("after_rst",       0, 0, 4'h0,   0, 2'b00, 4'h0,   0,  4'd0,   0, 0, 0, 0, 0, 3'd0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Session controller that sequences the ATM datapath: PIN check with lockout, then deposit, withdraw, inquiry and exit transactions against an internal balance register. Sits between the user-input front end (pin/amt/sel strobes) and the balance display and status flags. Owns the balance and attempt-count state, so the downstream datapath stays purely combinational.

Parameters:
W, 4, width of pin, amount and balance
MAX_TRIES, 3, wrong-PIN attempts before lockout (1..7)
INIT_BAL, 0, balance value loaded on reset
TIMEOUT, 15, idle cycles before auto-logout (used only with ATM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
card_in  in  1  card present level
prefed  in  W  stored reference PIN
pin  in  W  entered PIN
pin_valid  in  1  one-cycle strobe: pin is valid
sel  in  2  00 inquiry, 01 withdraw, 10 deposit, 11 exit
amt  in  W  transaction amount
txn_valid  in  1  one-cycle strobe: sel/amt are valid
dout  out  W  registered balance (always equals internal balance)
signal  out  1  lockout flag; high while LOCKED
wd  out  1  withdraw rejected (amt > balance); one-cycle pulse
ovf  out  1  deposit rejected (sum > 2^W-1); one-cycle pulse
done  out  1  transaction completed; one-cycle pulse
auth  out  1  high while in MENU
tries  out  3  wrong-attempt count

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, dout=INIT_BAL, signal=0, wd=0, ovf=0, done=0, auth=0, tries=0.
- IDLE: if card_in=1, go to PIN_WAIT on the next cycle. All strobes are ignored.
- PIN_WAIT, on pin_valid:
  - pin==prefed: go to MENU, tries<=0.
  - Mismatch: tries<=tries+1. If the new value equals MAX_TRIES, go to LOCKED. Otherwise stay in PIN_WAIT.
- MENU, on txn_valid (result visible the cycle after the strobe; latency 1):
  - 00: done=1, balance unchanged.
  - 01, amt<=bal: bal<=bal-amt, done=1.
  - 01, amt>bal: wd=1, done=0, balance unchanged.
  - 10, bal+amt<=2^W-1: bal<=bal+amt, done=1. Compute the sum W+1 bits wide.
  - 10, overflow: ovf=1, done=0, balance unchanged.
  - 11: done=1, go to IDLE, tries<=0.
  - amt=0 is legal: withdraw and deposit both complete with done=1 and no change.
- LOCKED: signal=1. Exit only by rst. card_in, pin_valid and txn_valid are ignored. tries holds MAX_TRIES.
- card_in=0 in PIN_WAIT or MENU: go to IDLE next cycle. Any same-cycle strobe is ignored. tries is retained, so lockout counts across card removal and clears only on correct PIN, exit, or rst.
- Strobes in the wrong state (pin_valid in MENU, txn_valid in PIN_WAIT) are ignored. Both strobes in the same cycle: only the one legal for the current state acts.
- rst mid-transaction wins over everything and restores reset values, including the balance.
- wd, ovf and done are never high together; each is a 1-cycle pulse.

Optional Feature:
Macro ATM_TIMEOUT_EN.
- Defined: a counter of ceil(log2(TIMEOUT+1)) bits runs in PIN_WAIT and MENU.
  - It clears on any accepted strobe or state change.
  - On reaching TIMEOUT it forces IDLE and clears auth. tries is retained.
- Undefined: no counter; sessions last until card_in=0 or exit.

Decomposition:
- Package atm_pkg: state enum (IDLE, PIN_WAIT, MENU, LOCKED); sel encodings SEL_INQ, SEL_WD, SEL_DEP, SEL_EXIT; default W.
- One sub-module, atm_balance_alu: combinational. Takes bal, amt and sel; returns next_bal, wd_err and ovf_err. It is reused by the existing display datapath.

Test Plan:
- Reset, card_in=1, prefed=0110, pin=0110 strobed -> auth=1 two cycles after card_in, tries=0, dout=0000.
- pin=0011 three times (MAX_TRIES=3) -> tries 1, 2, 3; signal=1 after the third; a later pin=0110 is ignored; only rst clears it.
- In MENU with bal=0: deposit amt=0101 -> dout=0101, done pulse. Withdraw amt=0011 -> dout=0010. Withdraw amt=0011 again -> wd=1, dout stays 0010.
- bal=1100, deposit amt=0101 -> ovf=1, dout stays 1100. Deposit amt=0011 -> dout=1111, done=1.
- Two wrong PINs, card removed and reinserted, one more wrong PIN -> LOCKED (count retained). sel=11 exit after a correct PIN -> IDLE, tries=0.
- With ATM_TIMEOUT_EN and TIMEOUT=15: 15 idle cycles in MENU -> IDLE, auth=0. A txn_valid at cycle 14 restarts the count.
